feature_window_sched: RTL and testbench

Raster-order read scheduler for the 27x27 single-channel feature buffer. On a start pulse it issues exactly one read per feature position, tags each returned pixel with its row and column, and flags the positions where a full KxK convolution window is available. It sits between the feature buffer and the convolution MAC array and is the only agent that drives the buffer's read enable.

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/raster_counter.sv | 42 ++++
 rtl/feature_window_sched.sv | 120 ++++++++++++
 tb/tb_feature_window_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution front end.
// Define FEATURE_SCHED_PAD_EN to schedule a "same" zero-padded grid.
package conv_pkg;

   localparam int unsigned IMG_W = 27;
   localparam int unsigned IMG_H = 27;
   localparam int unsigned K     = 3;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned PAD   = (K - 1) / 2;

   localparam int unsigned ROW_W = $clog2(IMG_H + K);
   localparam int unsigned COL_W = $clog2(IMG_W + K);

`ifdef FEATURE_SCHED_PAD_EN
   localparam int unsigned GRID_W = IMG_W + 2 * PAD;
   localparam int unsigned GRID_H = IMG_H + 2 * PAD;
`else
   localparam int unsigned GRID_W = IMG_W;
   localparam int unsigned GRID_H = IMG_H;
`endif

   typedef logic signed [PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } sched_state_e;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic             last;
   } pos_t;

   // A position completes a KxK window once K-1 rows and columns precede it.
   function automatic logic in_window(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col);
      return (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter with enable, synchronous clear and wrap;
// o_last flags the final position of the grid.
module raster_counter
   import conv_pkg::*;
#(
   parameter int unsigned CNT_ROW_W = ROW_W,
   parameter int unsigned CNT_COL_W = COL_W,
   parameter int unsigned WIDTH     = GRID_W,
   parameter int unsigned HEIGHT    = GRID_H
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   input  logic                 i_en,
   output logic [CNT_ROW_W-1:0] o_row,
   output logic [CNT_COL_W-1:0] o_col,
   output logic                 o_last
);

   localparam logic [CNT_ROW_W-1:0] ROW_END = CNT_ROW_W'(HEIGHT - 1);
   localparam logic [CNT_COL_W-1:0] COL_END = CNT_COL_W'(WIDTH - 1);

   logic col_end;

   assign col_end = (o_col == COL_END);
   assign o_last  = col_end && (o_row == ROW_END);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         o_row <= '0;
         o_col <= '0;
      end else if (i_en) begin
         if (col_end) begin
            o_col <= '0;
            o_row <= o_last ? '0 : o_row + CNT_ROW_W'(1);
         end else begin
            o_col <= o_col + CNT_COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/feature_window_sched.sv
// Raster-order read scheduler for the feature buffer: one read per position,
// pixels tagged with row/col/window flags. FEATURE_SCHED_PAD_EN adds zero padding.
module feature_window_sched
   import conv_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stall,
   output logic             o_rd_en,
   input  logic [PIX_W-1:0] i_feature,
   output logic [PIX_W-1:0] o_pixel,
   output logic             o_pixel_valid,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_win_valid,
   output logic             o_frame_done,
   output logic             o_busy
);

   sched_state_e     state;
   logic             issue;
   logic             issue_read;
   logic             issue_last;
   logic             cnt_clear;
   logic [ROW_W-1:0] issue_row;
   logic [COL_W-1:0] issue_col;

   logic             tag_valid;
   logic             tag_read;
   pos_t             tag;

   assign issue     = (state == STREAM) && !i_stall;
   assign cnt_clear = (state == IDLE) && i_start;

`ifdef FEATURE_SCHED_PAD_EN
   // Border positions take a pipeline slot but never touch the buffer.
   assign issue_read = (issue_row >= ROW_W'(PAD)) && (issue_row < ROW_W'(PAD + IMG_H)) &&
                       (issue_col >= COL_W'(PAD)) && (issue_col < COL_W'(PAD + IMG_W));
`else
   assign issue_read = 1'b1;
`endif

   assign o_rd_en = issue && issue_read;

   raster_counter #(
      .CNT_ROW_W (ROW_W),
      .CNT_COL_W (COL_W),
      .WIDTH     (GRID_W),
      .HEIGHT    (GRID_H)
   ) u_issue_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (cnt_clear),
      .i_en    (issue),
      .o_row   (issue_row),
      .o_col   (issue_col),
      .o_last  (issue_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         o_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state  <= STREAM;
                  o_busy <= 1'b1;
               end
            end
            STREAM: begin
               if (issue && issue_last) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // The final pixel is on the outputs this cycle.
               if (o_frame_done) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   // Tag stage aligns with buffer read data; output stage registers both.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_valid     <= 1'b0;
         tag_read      <= 1'b0;
         tag           <= '0;
         o_pixel_valid <= 1'b0;
         o_pixel       <= '0;
         o_row         <= '0;
         o_col         <= '0;
         o_win_valid   <= 1'b0;
         o_frame_done  <= 1'b0;
      end else begin
         tag_valid     <= issue;
         tag_read      <= issue_read;
         tag           <= '{row: issue_row, col: issue_col, last: issue_last};
         o_pixel_valid <= tag_valid;
         o_win_valid   <= tag_valid && in_window(tag.row, tag.col);
         o_frame_done  <= tag_valid && tag.last;
         if (tag_valid) begin
            o_pixel <= tag_read ? i_feature : '0;
            o_row   <= tag.row;
            o_col   <= tag.col;
         end
      end
   end

endmodule

// File: tb/tb_feature_window_sched.sv
// Randomized bench for feature_window_sched against a position-indexed model
// (expected emissions queued with their due cycle).
module tb_feature_window_sched;
   import conv_pkg::*;

`ifdef FEATURE_SCHED_PAD_EN
   localparam int P = PAD;
`else
   localparam int P = 0;
`endif
   localparam int GW   = IMG_W + 2 * P;
   localparam int GH   = IMG_H + 2 * P;
   localparam int N    = GW * GH;
   localparam int NPIX = IMG_W * IMG_H;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_start;
   logic             i_stall;
   logic             o_rd_en;
   logic [PIX_W-1:0] i_feature;
   logic [PIX_W-1:0] o_pixel;
   logic             o_pixel_valid;
   logic [ROW_W-1:0] o_row;
   logic [COL_W-1:0] o_col;
   logic             o_win_valid;
   logic             o_frame_done;
   logic             o_busy;

   always #5 i_clk = ~i_clk;

   feature_window_sched u_dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_stall       (i_stall),
      .o_rd_en       (o_rd_en),
      .i_feature     (i_feature),
      .o_pixel       (o_pixel),
      .o_pixel_valid (o_pixel_valid),
      .o_row         (o_row),
      .o_col         (o_col),
      .o_win_valid   (o_win_valid),
      .o_frame_done  (o_frame_done),
      .o_busy        (o_busy)
   );

   typedef struct {
      int due;
      int n;
   } pend_t;

   logic [7:0] mem [NPIX];
   pend_t      pend [$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         n_issue  = 0;
   int         buf_ptr  = 0;
   int         em_cnt   = 0;
   bit         issuing_m  = 1'b0;
   bit         busy_m     = 1'b0;
   bit         prev_rd    = 1'b0;
   bit         just_reset = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_border(input int n);
      int r = n / GW;
      int c = n % GW;
      return (r < P) || (r >= P + IMG_H) || (c < P) || (c >= P + IMG_W);
   endfunction

   function automatic logic [7:0] exp_pix(input int n);
      if (is_border(n)) return 8'd0;
      return mem[(n / GW - P) * IMG_W + (n % GW - P)];
   endfunction

   // One clock cycle: emulate the buffer, apply inputs, check, advance the model.
   task automatic step(input bit start, input bit stall, input bit rst);
      pend_t e;
      bit    hit;
      bit    done_now;
      bit    busy_old;
      @(posedge i_clk);
      #1;
      if (prev_rd) begin
         i_feature = mem[buf_ptr % NPIX];
         buf_ptr++;
      end else begin
         i_feature = 8'($urandom);
      end
      i_start = start;
      i_stall = stall;
      i_rst   = rst;
      #1;
      if (just_reset) begin
         check_eq("rst_pixel", 32'(o_pixel), 0);
         check_eq("rst_row", 32'(o_row), 0);
         check_eq("rst_col", 32'(o_col), 0);
         check_eq("rst_win", 32'(o_win_valid), 0);
      end
      check_eq("rd_en", 32'(o_rd_en), 32'(issuing_m && !stall && !is_border(n_issue)));
      check_eq("busy", 32'(o_busy), 32'(busy_m));
      hit = (pend.size() > 0) && (pend[0].due == cyc);
      check_eq("pix_valid", 32'(o_pixel_valid), 32'(hit));
      done_now = 1'b0;
      if (hit) begin
         e = pend.pop_front();
         check_eq("pixel", 32'(o_pixel), 32'(exp_pix(e.n)));
         check_eq("row", 32'(o_row), e.n / GW);
         check_eq("col", 32'(o_col), e.n % GW);
         check_eq("win", 32'(o_win_valid), 32'((e.n / GW >= K - 1) && (e.n % GW >= K - 1)));
         check_eq("frame_done", 32'(o_frame_done), 32'(e.n == N - 1));
         done_now = (e.n == N - 1);
         em_cnt++;
      end else begin
         check_eq("frame_done_idle", 32'(o_frame_done), 0);
      end
      prev_rd    = o_rd_en;
      just_reset = rst;
      if (rst) begin
         issuing_m = 1'b0;
         busy_m    = 1'b0;
         pend.delete();
         buf_ptr   = 0;
         prev_rd   = 1'b0;
      end else begin
         busy_old = busy_m;
         if (issuing_m && !stall) begin
            pend.push_back('{cyc + 2, n_issue});
            n_issue++;
            if (n_issue == N) issuing_m = 1'b0;
         end
         if (done_now) busy_m = 1'b0;
         if (!busy_old && start) begin
            busy_m    = 1'b1;
            issuing_m = 1'b1;
            n_issue   = 0;
            buf_ptr   = 0;
            em_cnt    = 0;
         end
      end
      cyc++;
   endtask

   initial begin
      int left;
      bit fired;
      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_stall   = 1'b0;
      i_feature = '0;
      for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
      repeat (3) @(posedge i_clk);

      // Unstalled frame, start pulsed at cycle 10.
      for (int i = 0; i < N + 40; i++) step(i == 10, 1'b0, 1'b0);

      // Five-cycle stall burst at row 5, column 13.
      left  = 0;
      fired = 1'b0;
      for (int i = 0; i < N + 60; i++) begin
         if (!fired && issuing_m && n_issue == 5 * GW + 13) begin
            fired = 1'b1;
            left  = 5;
         end
         step(i == 0, left > 0, 1'b0);
         if (left > 0) left--;
      end
      check_eq("stall_hit", 32'(fired), 1);

      // Random data, stalls and start pulses.
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 1'b0);
      end

      // Start held high: ignored while busy, back-to-back frames.
      for (int i = 0; i < 3 * N + 100; i++) step(1'b1, 1'b0, 1'b0);

      // Reset after 300 emitted pixels, then a clean frame.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int g = 0; g < 2 * N && em_cnt < 300; g++) begin
         step(1'b0, $urandom_range(0, 3) == 0, 1'b0);
      end
      check_eq("rst_point", 32'(em_cnt), 300);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < N + 40; i++) step(1'b0, 1'b0, 1'b0);
      check_eq("full_frame", 32'(em_cnt), N);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
